// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial subtractor built around one sub1 full-subtractor cell.
// The operands are processed LSB-first, one bit per clock, over WIDTH clocks.
// The borrow between bits is held in a flop.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   start    - request; accepted only in IDLE or DONE
//   a, b     - minuend / subtrahend, sampled on the accepting edge only
//   busy     - high while bits are being processed
//   done     - one-cycle pulse when the result registers update
//   diff     - a - b modulo 2^WIDTH
//   borrow   - final borrow-out (unsigned a < b)
//   zero     - diff == 0
//   overflow - two's-complement overflow of a - b
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one operand bit per cycle through sub1
// DONE  | results just loaded; may accept a new start

module sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  // Only WIDTH-1 result bits need storage; the last bit arrives from sub1
  // on the same edge the result registers load.
  logic [WIDTH-2:0] r_sr;
  logic [CW-1:0]    cnt;
  logic             brw_q;
  logic             a_msb, b_msb;
  logic             d_bit, bo_bit;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] r_final;

  sub1 u_sub1 (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw_q),
    .d    (d_bit),
    .bout (bo_bit)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign r_final = {d_bit, r_sr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are flops fed from the next-state decode so they line up
  // exactly with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == SHIFT);
      done <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      r_sr     <= '0;
      cnt      <= '0;
      brw_q    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      brw_q <= 1'b0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      r_sr  <= r_final[WIDTH-1:1];
      brw_q <= bo_bit;
      if (last) begin
        diff     <= r_final;
        borrow   <= bo_bit;
        zero     <= (r_final == '0);
        overflow <= (a_msb != b_msb) && (d_bit != a_msb);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_sub4.sv
module tb_serial_sub4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, zero, overflow;
  logic [W-1:0] diff;

  int checks   = 0;
  int failures = 0;

  // held-result model
  logic [W-1:0] h_diff = '0;
  logic         h_brw  = 1'b0;
  logic         h_zero = 1'b0;
  logic         h_ovf  = 1'b0;

  serial_sub4 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .borrow   (borrow),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         brw;
    logic         z;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_held(input string tag);
    chk({tag, " held diff"},   diff,     h_diff);
    chk({tag, " held borrow"}, borrow,   h_brw);
    chk({tag, " held zero"},   zero,     h_zero);
    chk({tag, " held ovf"},    overflow, h_ovf);
  endtask

  // Waits (at negedges) for done; returns edges counted since the accept edge.
  task automatic wait_done(input string tag, output int k);
    k = 0;
    while (!done && k <= W + 3) begin
      chk({tag, " busy in shift"}, busy, 1);
      chk_held(tag);
      @(negedge clk);
      k++;
    end
    if (!done) chk({tag, " done timeout"}, 0, 1);
    chk({tag, " busy&done"}, busy & done, 0);
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, " diff"},     diff,     v.d);
    chk({tag, " borrow"},   borrow,   v.brw);
    chk({tag, " zero"},     zero,     v.z);
    chk({tag, " overflow"}, overflow, v.ovf);
    h_diff = v.d; h_brw = v.brw; h_zero = v.z; h_ovf = v.ovf;
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int k;
    @(negedge clk);
    a = v.a; b = v.b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    wait_done(tag, k);
    chk({tag, " latency"}, k, W);
    chk_result(tag, v);
    @(negedge clk);
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    int k;
    vec_t v;
    vecs[0] = '{4'h5, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'h3, 4'h5, 4'hE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{4'h7, 4'hF, 4'h8, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{4'h0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{4'h8, 4'h7, 4'h1, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{4'hA, 4'h3, 4'h7, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk_held("rst");
    rst = 1'b0;

    foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i]);

    // back-to-back: start held through SHIFT and DONE
    @(negedge clk);
    a = 4'h7; b = 4'h7; start = 1'b1;
    @(negedge clk);
    a = 4'h9; b = 4'h2;
    wait_done("b2b1", k);
    chk("b2b1 latency", k, W);
    v = '{4'h7, 4'h7, 4'h0, 1'b0, 1'b1, 1'b0};
    chk_result("b2b1", v);
    @(negedge clk);
    start = 1'b0; a = 4'h0; b = 4'h0;
    chk("b2b accept busy", busy, 1);
    chk("b2b accept done", done, 0);
    wait_done("b2b2", k);
    chk("b2b2 latency", k, W);
    v = '{4'h9, 4'h2, 4'h7, 1'b0, 1'b0, 1'b1};
    chk_result("b2b2", v);

    // start during SHIFT is ignored
    @(negedge clk);
    a = 4'h5; b = 4'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'h0; b = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", k);
    chk("ign latency", k, W - 2);
    v = '{4'h5, 4'h3, 4'h2, 1'b0, 1'b0, 1'b0};
    chk_result("ign", v);
    @(negedge clk);
    chk("ign no restart", busy, 0);

    // reset mid-operation
    @(negedge clk);
    a = 4'hE; b = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid rst busy", busy, 0);
    chk("mid rst done", done, 0);
    h_diff = '0; h_brw = 1'b0; h_zero = 1'b0; h_ovf = 1'b0;
    chk_held("mid rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post rst idle busy", busy, 0);
      chk("post rst idle done", done, 0);
    end
    v = '{4'h1, 4'h0, 4'h1, 1'b0, 1'b0, 1'b0};
    run_op("post rst", v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
endmodule
